md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl.sv | 164 ++++++++++++++++
 tb/tb_md_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO multiply/divide unit with hazard stall generation.
//
// Multi-cycle MULT/MULTU/DIV/DIVU: the full 64-bit result is computed at the
// start edge and held in pending registers (phi/plo). The architectural HI/LO
// registers are only updated when the busy countdown expires, which mimics
// the latency of an iterative unit. MTHI/MTLO write HI/LO directly when idle.
//
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-low reset
//   md_op   - E-stage op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI,
//             6 MTLO, 7 reserved (none)
//   a, b    - forwarded rs / rt operands in E
//   md_useD - D-stage instruction touches HI/LO
//   busy    - multi-cycle operation in progress
//   stallD  - freeze PC and IF/ID, bubble into E
//   hi, lo  - architectural HI / LO registers
//
// MULT_CYCLES and DIV_CYCLES must lie in 1..31 (5-bit countdown).
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_useD,
    output logic        busy,
    output logic        stallD,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] phi;
    logic [31:0] plo;

    logic               start_op;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [63:0] mul_s;
    logic        [63:0] mul_u;
    logic        [63:0] div_s;
    logic        [63:0] div_u;

    // Signed divide returning {remainder, quotient}. A zero divisor returns
    // 'keep' so HI/LO end up unchanged; the one overflowing case
    // (most-negative / -1) is pinned to quotient 0x80000000, remainder 0.
    function automatic logic [63:0] sdiv(input logic signed [31:0] n,
                                         input logic signed [31:0] d,
                                         input logic        [63:0] keep);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (d == 32'sd0) begin
            return keep;
        end else if (n == 32'sh80000000 && d == -32'sd1) begin
            return {32'd0, 32'h80000000};
        end else begin
            q = n / d;
            r = n % d;
            return {r, q};
        end
    endfunction

    // Unsigned divide returning {remainder, quotient}; zero divisor keeps HI/LO.
    function automatic logic [63:0] udiv(input logic [31:0] n,
                                         input logic [31:0] d,
                                         input logic [63:0] keep);
        if (d == 32'd0) begin
            return keep;
        end else begin
            return {n % d, n / d};
        end
    endfunction

    assign a_s   = a;
    assign b_s   = b;
    assign mul_s = 64'(a_s) * 64'(b_s);
    assign mul_u = {32'd0, a} * {32'd0, b};
    assign div_s = sdiv(a_s, b_s, {hi, lo});
    assign div_u = udiv(a, b, {hi, lo});

    assign start_op = (md_op >= OP_MULT) && (md_op <= OP_DIVU);

    // A start in E also stalls D, since busy only rises after the start edge.
    assign stallD = md_useD & (busy | start_op);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            phi   <= 32'd0;
            plo   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    case (md_op)
                        OP_MULT: begin
                            {phi, plo} <= mul_s;
                            cnt        <= MUL_LOAD;
                            state      <= MUL_RUN;
                            busy       <= 1'b1;
                        end
                        OP_MULTU: begin
                            {phi, plo} <= mul_u;
                            cnt        <= MUL_LOAD;
                            state      <= MUL_RUN;
                            busy       <= 1'b1;
                        end
                        OP_DIV: begin
                            {phi, plo} <= div_s;
                            cnt        <= DIV_LOAD;
                            state      <= DIV_RUN;
                            busy       <= 1'b1;
                        end
                        OP_DIVU: begin
                            {phi, plo} <= div_u;
                            cnt        <= DIV_LOAD;
                            state      <= DIV_RUN;
                            busy       <= 1'b1;
                        end
                        OP_MTHI: hi <= a;
                        OP_MTLO: lo <= a;
                        default: ;
                    endcase
                end
                MUL_RUN, DIV_RUN: begin
                    // md_op is ignored here; the pipeline stall keeps it idle.
                    if (cnt == 5'd0) begin
                        hi    <= phi;
                        lo    <= plo;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: scoreboard bench for md_ctrl. The stimulus process pushes the
// expected HI/LO and busy length of every multi-cycle op into a queue; the
// monitor pops and compares whenever busy falls. Expected results come from
// a 64-bit arithmetic reference model.
module tb_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic [2:0]  md_op   = 3'd0;
    logic [31:0] a       = 32'd0;
    logic [31:0] b       = 32'd0;
    logic        md_useD = 1'b0;
    logic        busy;
    logic        stallD;
    logic [31:0] hi;
    logic [31:0] lo;

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .a(a), .b(b),
        .md_useD(md_useD), .busy(busy), .stallD(stallD), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: {new_hi, new_lo} for an op issued with current h/l.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sx, sy, ax, ay, q, rm;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            3'd1: return sx * sy;
            3'd2: begin
                ux = {32'd0, x};
                uy = {32'd0, y};
                return ux * uy;
            end
            3'd3: begin
                if (y == 32'd0) return {h, l};
                ax = (sx < 0) ? -sx : sx;
                ay = (sy < 0) ? -sy : sy;
                q  = ax / ay;
                rm = ax - q * ay;
                if (x[31] ^ y[31]) q = -q;
                if (x[31]) rm = -rm;
                return {rm[31:0], q[31:0]};
            end
            3'd4: begin
                if (y == 32'd0) return {h, l};
                return {x % y, x / y};
            end
            3'd5: return {x, l};
            3'd6: return {h, x};
            default: return {h, l};
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: count busy cycles, compare on every completion.
    initial begin : monitor
        bit   prev;
        int   bc;
        exp_t e;
        prev = 1'b0;
        bc   = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = 1'b0;
                bc   = 0;
            end else begin
                if (busy) begin
                    bc++;
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: hi %h lo %h with empty queue", hi, lo);
                    end else begin
                        e = sb.pop_front();
                        chk("done_hi", hi, e.hi);
                        chk("done_lo", lo, e.lo);
                        chk("busy_len", 32'(bc), 32'(e.n));
                    end
                    bc = 0;
                end
                prev = busy;
            end
        end
    end

    // Issue one op. directed=1 holds md_useD high and offers MTHI 0x5 during busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input bit directed);
        logic [63:0] r;
        int          n;
        bit          is_start;
        @(posedge clk); #1;
        md_op    = op;
        a        = x;
        b        = y;
        md_useD  = directed ? 1'b1 : 1'($urandom_range(0, 1));
        is_start = (op >= 3'd1) && (op <= 3'd4);
        @(negedge clk);
        chk("stall_issue", 32'(stallD), 32'(md_useD & is_start));
        @(posedge clk); #1;
        r = model(op, x, y, m_hi, m_lo);
        if (is_start) begin
            n = (op <= 3'd2) ? MC : DC;
            sb.push_back('{r[63:32], r[31:0], n});
            m_hi = r[63:32];
            m_lo = r[31:0];
            for (int k = 0; k < n; k++) begin
                if (directed) begin
                    md_op   = 3'd5;
                    a       = 32'h5;
                    md_useD = 1'b1;
                end else begin
                    md_op   = 3'($urandom_range(0, 7));
                    a       = $urandom;
                    b       = $urandom;
                    md_useD = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                chk("busy_run", 32'(busy), 32'd1);
                chk("stall_run", 32'(stallD), 32'(md_useD));
                @(posedge clk); #1;
            end
            md_op   = 3'd0;
            md_useD = directed;
            @(negedge clk);
            chk("busy_after", 32'(busy), 32'd0);
            chk("stall_after", 32'(stallD), 32'd0);
        end else begin
            md_op   = 3'd0;
            md_useD = 1'b0;
            m_hi    = r[63:32];
            m_lo    = r[31:0];
            @(negedge clk);
            chk("idle_hi", hi, m_hi);
            chk("idle_lo", lo, m_lo);
            chk("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [2:0] rop;
        // Reset state, stallD with busy forced low
        md_useD = 1'b1;
        #2;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stallD), 32'd0);
        md_op = 3'd3;
        #1;
        chk("rst_stall_start", 32'(stallD), 32'd1);
        md_op   = 3'd0;
        md_useD = 1'b0;
        #9 reset = 1'b1;

        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_lo", lo, 32'hFFFFFFFD);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("divovf_hi", hi, 32'h0);
        chk("divovf_lo", lo, 32'h80000000);
        run_op(3'd5, 32'h11, 32'd0, 1'b0);
        run_op(3'd6, 32'h22, 32'd0, 1'b0);
        run_op(3'd4, 32'h1234, 32'd0, 1'b0);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);
        run_op(3'd3, 32'd1000, 32'd7, 1'b1);
        chk("mthi_ignored", hi, 32'd6);

        // Reset in the third busy cycle of a DIV aborts it.
        @(posedge clk); #1;
        md_op   = 3'd3;
        a       = 32'd99;
        b       = 32'd4;
        md_useD = 1'b1;
        @(posedge clk); #1;
        md_op = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("abort_busy", 32'(busy), 32'd1);
            if (k < 3) begin
                @(posedge clk); #1;
            end
        end
        #2 reset = 1'b0;
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy0", 32'(busy), 32'd0);
        chk("abort_stall", 32'(stallD), 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        @(posedge clk); #3;
        reset   = 1'b1;
        md_useD = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_nocommit_hi", hi, 32'd0);
        chk("abort_nocommit_lo", lo, 32'd0);
        chk("abort_nocommit_busy", 32'(busy), 32'd0);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            run_op(rop, pick(), pick(), 1'b0);
        end

        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
